// File: rtl/arb_adder_fp.sv
// Round-robin arbiter that time-shares one floating-point adder between N_REQ requesters.
// One transaction at a time: grant, start pulse, wait for done under a watchdog, return result.
module arb_adder_fp #(
  parameter int SIZE     = 64,
  parameter int EXPONENT = 5 + ($clog2(SIZE) - 4) * 3,
  parameter int FRACTION = SIZE - EXPONENT - 1,
  parameter int N_REQ    = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*SIZE-1:0]   i_op_a,
  input  logic [N_REQ*SIZE-1:0]   i_op_b,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_fpu_start,
  output logic [SIZE-1:0]         o_fpu_a,
  output logic [SIZE-1:0]         o_fpu_b,
  input  logic                    i_fpu_done,
  input  logic [SIZE-1:0]         i_fpu_result,
  output logic [N_REQ-1:0]        o_valid,
  output logic [SIZE-1:0]         o_result,
  output logic                    o_timeout,
  output logic                    o_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT);
  localparam logic [PW-1:0]    LAST = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0]  QNAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              start_q, start_d;
  logic [SIZE-1:0]   fpu_a_q, fpu_a_d;
  logic [SIZE-1:0]   fpu_b_q, fpu_b_d;
  logic [N_REQ-1:0]  valid_q, valid_d;
  logic [SIZE-1:0]   result_q, result_d;
  logic              timeout_q, timeout_d;
  logic              pick_found;
  logic [PW-1:0]     pick_idx;

  // Round-robin pick: first pending request at or above ptr, wrapping to 0.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!pick_found && i_req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end else begin
        pick_idx   = pick_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) state_d = S_START;
        else            state_d = S_IDLE;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_fpu_done || (timer_q == TMAX)) state_d = S_RESP;
        else                                 state_d = S_WAIT;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    fpu_a_d   = fpu_a_q;
    fpu_b_d   = fpu_b_q;
    result_d  = result_q;
    gnt_d     = '0;
    start_d   = 1'b0;
    valid_d   = '0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          fpu_a_d = i_op_a[int'(pick_idx)*SIZE +: SIZE];
          fpu_b_d = i_op_b[int'(pick_idx)*SIZE +: SIZE];
          gnt_d   = ONE << pick_idx;
          start_d = 1'b1;
        end else begin
          owner_d = owner_q;
        end
      end
      S_START: timer_d = '0;
      S_WAIT: begin
        if (i_fpu_done) begin
          result_d = i_fpu_result;
          valid_d  = ONE << owner_q;
        end else if (timer_q == TMAX) begin
          result_d  = QNAN;
          valid_d   = ONE << owner_q;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP:  ptr_d = (owner_q == LAST) ? '0 : owner_q + PW'(1);
      default: ptr_d = ptr_q;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      timer_q   <= '0;
      gnt_q     <= '0;
      start_q   <= 1'b0;
      fpu_a_q   <= '0;
      fpu_b_q   <= '0;
      valid_q   <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      fpu_a_q   <= fpu_a_d;
      fpu_b_q   <= fpu_b_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_fpu_start = start_q;
  assign o_fpu_a     = fpu_a_q;
  assign o_fpu_b     = fpu_b_q;
  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_arb_adder_fp.sv
// Scoreboard bench for arb_adder_fp: a round-robin reference model predicts grant order,
// operands, results and latencies; a monitor compares whatever the DUT presents.
module tb_arb_adder_fp;

  localparam int SIZE    = 64;
  localparam int N       = 4;
  localparam int TO      = 8;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [N-1:0]      i_req = '0;
  logic [N*SIZE-1:0] i_op_a = '0;
  logic [N*SIZE-1:0] i_op_b = '0;
  logic [N-1:0]      o_gnt;
  logic              o_fpu_start;
  logic [SIZE-1:0]   o_fpu_a, o_fpu_b;
  logic              i_fpu_done = 1'b0;
  logic [SIZE-1:0]   i_fpu_result = '0;
  logic [N-1:0]      o_valid;
  logic [SIZE-1:0]   o_result;
  logic              o_timeout;
  logic              o_busy;

  arb_adder_fp #(.SIZE(SIZE), .N_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .o_gnt(o_gnt), .o_fpu_start(o_fpu_start), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b),
    .i_fpu_done(i_fpu_done), .i_fpu_result(i_fpu_result), .o_valid(o_valid),
    .o_result(o_result), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct { logic [N-1:0] gnt; logic [63:0] a; logic [63:0] b; bit b2b; } gexp_t;
  typedef struct { logic [N-1:0] valid; logic [63:0] res; bit tmo; int lat; } vexp_t;

  gexp_t gq[$];
  vexp_t vq[$];
  int    dq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    mptr    = 0;
  bit    saw_late = 1'b0;
  logic [63:0] op_a_arr[N];
  logic [63:0] op_b_arr[N];
  int          ph_delay[N];

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rnd_real();
    return $realtobits(($itor($urandom_range(0, 4000)) - 2000.0) / 8.0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Behavioural adder: done d cycles after start (d=0 never answers); keeps counting through reset.
  initial begin : fpu_model
    int cnt;
    logic [63:0] ra, rb;
    cnt = 0; ra = '0; rb = '0;
    forever begin
      @(negedge i_clk);
      i_fpu_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i_fpu_done   = 1'b1;
          i_fpu_result = fadd(ra, rb);
          if (!o_busy) saw_late = 1'b1;
        end
      end
      if (o_fpu_start && !i_rst) begin
        if (dq.size() == 0) cnt = 0;
        else                cnt = dq.pop_front();
        ra = o_fpu_a;
        rb = o_fpu_b;
      end
    end
  end

  // Monitor: pop and compare whenever a grant or a result is presented.
  initial begin : monitor
    int gnt_cyc, last_vcyc;
    gexp_t g;
    vexp_t v;
    gnt_cyc = 0; last_vcyc = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_gnt != '0) begin
          if (gq.size() == 0) check("unexpected_gnt", {60'd0, o_gnt}, 64'd0);
          else begin
            g = gq.pop_front();
            check("gnt", {60'd0, o_gnt}, {60'd0, g.gnt});
            check("fpu_start_with_gnt", {63'd0, o_fpu_start}, 64'd1);
            check("fpu_a", o_fpu_a, g.a);
            check("fpu_b", o_fpu_b, g.b);
            if (g.b2b) check("gnt_gap", 64'(cyc - last_vcyc), 64'd2);
          end
          gnt_cyc = cyc;
        end else if (o_fpu_start) begin
          check("start_without_gnt", {63'd0, o_fpu_start}, 64'd0);
        end
        if (o_valid != '0) begin
          if (vq.size() == 0) check("unexpected_valid", {60'd0, o_valid}, 64'd0);
          else begin
            v = vq.pop_front();
            check("valid", {60'd0, o_valid}, {60'd0, v.valid});
            check("result", o_result, v.res);
            check("timeout_flag", {63'd0, o_timeout}, {63'd0, v.tmo});
            check("latency", 64'(cyc - gnt_cyc), 64'(v.lat));
          end
          last_vcyc = cyc;
        end else if (o_timeout) begin
          check("timeout_without_valid", {63'd0, o_timeout}, 64'd0);
        end
      end
    end
  end

  // Predict the whole phase, then present the requests and hold each until granted.
  task automatic run_phase(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    bit b2b;
    bit ok;
    int owner, d;
    gexp_t g;
    vexp_t v;
    pend = mask; b2b = 1'b0;
    while (pend != '0) begin
      owner = -1;
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (mptr + i) % N;
        if (owner < 0 && pend[idx]) owner = idx;
      end
      d       = ph_delay[owner];
      g.gnt   = N'(1) << owner;
      g.a     = op_a_arr[owner];
      g.b     = op_b_arr[owner];
      g.b2b   = b2b;
      v.valid = N'(1) << owner;
      v.tmo   = (d == 0) || (d > TO + 1);
      v.res   = v.tmo ? QNAN : fadd(op_a_arr[owner], op_b_arr[owner]);
      v.lat   = v.tmo ? TO + 2 : d + 1;
      gq.push_back(g);
      vq.push_back(v);
      dq.push_back(d);
      b2b = 1'b1;
      pend[owner] = 1'b0;
      mptr = (owner + 1) % N;
    end
    for (int k = 0; k < N; k++) begin
      i_op_a[k*SIZE +: SIZE] = op_a_arr[k];
      i_op_b[k*SIZE +: SIZE] = op_b_arr[k];
    end
    i_req = mask;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge i_clk);
      i_req = i_req & ~o_gnt;
      if (vq.size() == 0 && i_req == '0) ok = 1'b1;
    end
    if (!ok) begin
      check("phase_bound", 64'(vq.size()), 64'd0);
      gq.delete(); vq.delete(); dq.delete();
      i_req = '0;
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic set_ops(input bit random_ops, input int dly);
    for (int k = 0; k < N; k++) begin
      op_a_arr[k] = rnd_real();
      op_b_arr[k] = rnd_real();
      ph_delay[k] = random_ops ? $urandom_range(1, TO + 1) : dly;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},     {60'd0, o_gnt},       64'd0);
    check({tag, "_start"},   {63'd0, o_fpu_start}, 64'd0);
    check({tag, "_fpu_a"},   o_fpu_a,              64'd0);
    check({tag, "_fpu_b"},   o_fpu_b,              64'd0);
    check({tag, "_valid"},   {60'd0, o_valid},     64'd0);
    check({tag, "_result"},  o_result,             64'd0);
    check({tag, "_timeout"}, {63'd0, o_timeout},   64'd0);
    check({tag, "_busy"},    {63'd0, o_busy},      64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin : stim
    bit got;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Fairness: all four held, done after one cycle, then requester 0 again.
    set_ops(1'b0, 1);
    run_phase(4'b1111);
    run_phase(4'b0001);

    // Single request with known operands.
    set_ops(1'b0, 5);
    op_a_arr[0] = 64'h3FF0000000000000;
    op_b_arr[0] = 64'h4000000000000000;
    run_phase(4'b0001);

    // Wrap: move ptr to 2, then 0011 must grant 0 first; then ptr=1 steers 1001 to 3.
    set_ops(1'b0, 2);
    run_phase(4'b0010);
    run_phase(4'b0011);
    run_phase(4'b0001);
    run_phase(4'b1001);

    // Timeout (no done), then a normal transaction.
    set_ops(1'b0, 0);
    run_phase(4'b0100);
    set_ops(1'b0, 3);
    run_phase(4'b0010);

    // Done coincides with the watchdog limit.
    set_ops(1'b0, TO + 1);
    run_phase(4'b1000);

    // Random phases.
    for (int p = 0; p < 8; p++) begin
      set_ops(1'b1, 0);
      run_phase(N'($urandom_range(1, 15)));
    end

    // Reset mid-transaction: owner 2, adder would answer 8 cycles after start.
    set_ops(1'b0, 8);
    op_a_arr[2] = 64'h3FF8000000000000;
    op_b_arr[2] = 64'h3FF8000000000000;
    gq.push_back('{gnt: 4'b0100, a: op_a_arr[2], b: op_b_arr[2], b2b: 1'b0});
    dq.push_back(8);
    i_op_a[2*SIZE +: SIZE] = op_a_arr[2];
    i_op_b[2*SIZE +: SIZE] = op_b_arr[2];
    i_req = 4'b0100;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge i_clk);
      if (o_gnt != '0) got = 1'b1;
    end
    check("rst_test_grant_seen", {63'd0, got}, 64'd1);
    i_req = '0;
    repeat (2) @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    mptr = 0;
    gq.delete(); vq.delete(); dq.delete();
    repeat (12) @(negedge i_clk);
    check("late_done_delivered", {63'd0, saw_late}, 64'd1);

    // Round-robin restarts at requester 0.
    set_ops(1'b0, 1);
    run_phase(4'b1111);

    check("queues_drained", 64'(gq.size() + vq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
